lfsr_burst_sched: RTL and testbench

//  Sequences the 8-bit LFSR pattern generator (clk_en/rst/data) to feed a UART TX byte stream.
//  On start: reseeds the LFSR, sends burst_len pattern bytes over a valid/ready handshake,
//  and inserts gap_cycles idle cycles between bytes. Used in the UART bench/demo as a traffic source.

---
 rtl/lfsr_burst_sched.sv | 117 +++++++++++
 tb/tb_lfsr_burst_sched.sv | 208 ++++++++++++++++++++
 2 files changed

// File: rtl/lfsr_burst_sched.sv
// Burst scheduler that reseeds an external 8-bit LFSR and streams its bytes
// to a UART TX over valid/ready, with a programmable idle gap between bytes.
module lfsr_burst_sched #(
    parameter int CNT_W = 16,
    parameter int GAP_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             abort,
    input  logic [CNT_W-1:0] burst_len,
    input  logic [GAP_W-1:0] gap_cycles,
    input  logic [7:0]       lfsr_data,
    output logic             lfsr_rst,
    output logic             lfsr_en,
    output logic [7:0]       tx_data,
    output logic             tx_valid,
    input  logic             tx_ready,
    output logic             busy,
    output logic             done,
    output logic [CNT_W-1:0] byte_count
);

    typedef enum logic [2:0] {IDLE, SEED, LOAD, SEND, GAP} state_t;

    state_t           state, state_n;
    logic [CNT_W-1:0] len_q, len_n, cnt_n;
    logic [GAP_W-1:0] gap_q, gap_n, gcnt, gcnt_n;
    logic [7:0]       data_n;
    logic             valid_n, done_n, hs;

    assign hs = (state == SEND) && tx_valid && tx_ready;

    // The LFSR must step on the handshake edge itself so the following LOAD
    // already sees the next pattern byte; this is the only unregistered output.
    assign lfsr_en = rst && hs;

    always_comb begin
        state_n = state;
        len_n   = len_q;
        gap_n   = gap_q;
        gcnt_n  = gcnt;
        cnt_n   = byte_count;
        data_n  = tx_data;
        valid_n = tx_valid;
        done_n  = 1'b0;
        case (state)
            IDLE: begin
                if (start && burst_len != '0) begin
                    len_n   = burst_len;
                    gap_n   = gap_cycles;
                    cnt_n   = '0;
                    state_n = SEED;
                end
            end
            SEED: state_n = LOAD;
            LOAD: begin
                data_n  = lfsr_data;
                valid_n = 1'b1;
                state_n = SEND;
            end
            SEND: begin
                if (hs) begin
                    valid_n = 1'b0;
                    cnt_n   = byte_count + CNT_W'(1);
                    if (cnt_n == len_q) begin
                        state_n = IDLE;
                        done_n  = 1'b1;
                    end else if (gap_q == '0) begin
                        state_n = LOAD;
                    end else begin
                        state_n = GAP;
                        gcnt_n  = gap_q;
                    end
                end
            end
            GAP: begin
                if (gcnt <= GAP_W'(1)) state_n = LOAD;
                else                   gcnt_n  = gcnt - GAP_W'(1);
            end
            default: state_n = IDLE;
        endcase
        // Abort keeps any byte counted on this same edge but never signals done.
        if (abort && state != IDLE) begin
            state_n = IDLE;
            valid_n = 1'b0;
            done_n  = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state      <= IDLE;
            len_q      <= '0;
            gap_q      <= '0;
            gcnt       <= '0;
            byte_count <= '0;
            tx_data    <= '0;
            tx_valid   <= 1'b0;
            done       <= 1'b0;
            busy       <= 1'b0;
            lfsr_rst   <= 1'b1;
        end else begin
            state      <= state_n;
            len_q      <= len_n;
            gap_q      <= gap_n;
            gcnt       <= gcnt_n;
            byte_count <= cnt_n;
            tx_data    <= data_n;
            tx_valid   <= valid_n;
            done       <= done_n;
            busy       <= (state_n != IDLE);
            lfsr_rst   <= (state_n == SEED);
        end
    end

endmodule

// File: tb/tb_lfsr_burst_sched.sv
// Directed bench for lfsr_burst_sched with a behavioural 8-bit LFSR
// (taps 7,5,4,3, seed 0xFF) standing in for the pattern generator.
module tb_lfsr_burst_sched;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        start = 1'b0;
    logic        abort = 1'b0;
    logic [15:0] burst_len = '0;
    logic [7:0]  gap_cycles = '0;
    logic [7:0]  lfsr = 8'h00;
    logic        lfsr_rst, lfsr_en;
    logic [7:0]  tx_data;
    logic        tx_valid;
    logic        tx_ready = 1'b0;
    logic        busy, done;
    logic [15:0] byte_count;

    int total = 0;
    int bad   = 0;
    logic [7:0] pat [0:5] = '{8'hFF, 8'hFE, 8'hFC, 8'hF8, 8'hF0, 8'hE1};

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (lfsr_rst)     lfsr <= 8'hFF;
        else if (lfsr_en) lfsr <= {lfsr[6:0], lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3]};
    end

    lfsr_burst_sched #(.CNT_W(16), .GAP_W(8)) dut (
        .clk(clk), .rst(rst), .start(start), .abort(abort),
        .burst_len(burst_len), .gap_cycles(gap_cycles), .lfsr_data(lfsr),
        .lfsr_rst(lfsr_rst), .lfsr_en(lfsr_en), .tx_data(tx_data),
        .tx_valid(tx_valid), .tx_ready(tx_ready), .busy(busy), .done(done),
        .byte_count(byte_count)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    initial begin
        int k, n;
        // reset values
        tick(); tick();
        chk("rst_valid", tx_valid, 0);
        chk("rst_data", tx_data, 0);
        chk("rst_lfsr_rst", lfsr_rst, 1);
        chk("rst_lfsr_en", lfsr_en, 0);
        chk("rst_done", done, 0);
        chk("rst_busy", busy, 0);
        chk("rst_count", byte_count, 0);
        rst = 1'b1;
        tick();
        chk("idle_lfsr_rst", lfsr_rst, 0);

        // 1: len=4, gap=0, always ready
        burst_len = 16'd4; gap_cycles = 8'd0; tx_ready = 1'b1; start = 1'b1;
        tick(); start = 1'b0;
        chk("t1_seed_busy", busy, 1);
        chk("t1_seed_lfsr_rst", lfsr_rst, 1);
        chk("t1_seed_valid", tx_valid, 0);
        tick();
        chk("t1_load_valid", tx_valid, 0);
        tick();
        for (int i = 0; i < 4; i++) begin
            chk("t1_valid", tx_valid, 1);
            chk("t1_data", tx_data, pat[i]);
            chk("t1_lfsr_en", lfsr_en, 1);
            tick();
            chk("t1_valid_drop", tx_valid, 0);
            chk("t1_done", done, (i == 3) ? 1 : 0);
            if (i < 3) tick();
        end
        chk("t1_busy_end", busy, 0);
        chk("t1_count", byte_count, 4);
        tick();
        chk("t1_done_pulse", done, 0);

        // 2: len=6, ready one cycle in three
        burst_len = 16'd6; tx_ready = 1'b0; start = 1'b1;
        tick(); start = 1'b0;
        k = 0;
        for (int c = 0; c < 100 && k < 6; c++) begin
            tx_ready = (c % 3 == 2);
            if (tx_valid) chk("t2_data", tx_data, pat[k]);
            if (tx_valid && tx_ready) k++;
            tick();
        end
        tx_ready = 1'b0;
        chk("t2_bytes", k, 6);
        chk("t2_done", done, 1);
        chk("t2_count", byte_count, 6);

        // 3: len=3, gap=5
        burst_len = 16'd3; gap_cycles = 8'd5; tx_ready = 1'b1; start = 1'b1;
        tick(); start = 1'b0;
        chk("t3_seed_valid", tx_valid, 0);
        tick();
        chk("t3_load_valid", tx_valid, 0);
        tick();
        chk("t3_first_valid", tx_valid, 1);
        chk("t3_data0", tx_data, pat[0]);
        for (int i = 1; i < 3; i++) begin
            tick();
            n = 0;
            while (!tx_valid && n < 20) begin
                chk("t3_busy_gap", busy, 1);
                tick();
                n++;
            end
            chk("t3_gap_len", n, 6);
            chk("t3_data", tx_data, pat[i]);
        end
        tick();
        chk("t3_done", done, 1);
        chk("t3_count", byte_count, 3);

        // 4a: abort while stalled in SEND after two bytes
        burst_len = 16'd5; gap_cycles = 8'd0; tx_ready = 1'b1; start = 1'b1;
        tick(); start = 1'b0;
        tick(); tick();
        tick(); tick();
        tick();
        tx_ready = 1'b0;
        tick();
        chk("t4a_stall_data", tx_data, pat[2]);
        abort = 1'b1;
        tick(); abort = 1'b0;
        chk("t4a_valid", tx_valid, 0);
        chk("t4a_done", done, 0);
        chk("t4a_busy", busy, 0);
        chk("t4a_count", byte_count, 2);
        tick();
        chk("t4a_done_later", done, 0);

        // 4b: abort on the handshake of the third byte
        tx_ready = 1'b1; start = 1'b1;
        tick(); start = 1'b0;
        tick(); tick();
        tick(); tick();
        tick(); tick();
        chk("t4b_data", tx_data, pat[2]);
        chk("t4b_lfsr_en", lfsr_en, 1);
        abort = 1'b1;
        tick(); abort = 1'b0; tx_ready = 1'b0;
        chk("t4b_valid", tx_valid, 0);
        chk("t4b_done", done, 0);
        chk("t4b_count", byte_count, 3);
        chk("t4b_lfsr_adv", lfsr, 8'hF8);

        // 5: zero-length start ignored; start while busy ignored
        burst_len = 16'd0; start = 1'b1;
        tick(); start = 1'b0;
        chk("t5_len0_busy", busy, 0);
        chk("t5_len0_seed", lfsr_rst, 0);
        chk("t5_len0_count", byte_count, 3);
        burst_len = 16'd2; start = 1'b1;
        tick(); start = 1'b0;
        tick(); tick();
        burst_len = 16'd7; start = 1'b1;
        tick(); start = 1'b0;
        chk("t5_busy_valid", tx_valid, 1);
        chk("t5_busy_data", tx_data, pat[0]);
        chk("t5_busy_count", byte_count, 0);
        tx_ready = 1'b1;
        tick(); tick(); tick();
        chk("t5_done", done, 1);
        chk("t5_count", byte_count, 2);
        tx_ready = 1'b0;

        // 6: reset mid-burst, then replay from 0xFF
        burst_len = 16'd4; tx_ready = 1'b1; start = 1'b1;
        tick(); start = 1'b0;
        tick(); tick(); tick(); tick();
        chk("t6_pre_data", tx_data, pat[1]);
        rst = 1'b0;
        tick();
        chk("t6_valid", tx_valid, 0);
        chk("t6_lfsr_rst", lfsr_rst, 1);
        chk("t6_busy", busy, 0);
        chk("t6_done", done, 0);
        chk("t6_count", byte_count, 0);
        rst = 1'b1;
        tick();
        burst_len = 16'd2; start = 1'b1;
        tick(); start = 1'b0;
        tick(); tick();
        chk("t6_replay0", tx_data, pat[0]);
        tick(); tick();
        chk("t6_replay1", tx_data, pat[1]);
        tick();
        chk("t6_replay_done", done, 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
